// File: rtl/fft_power_averager.sv
// fft_power_averager
//
// Turns a stream of complex FFT bins into averaged power spectra. Each bin's
// power re*re + im*im is accumulated per bin over 2^L consecutive spectra in a
// FFT_LENGTH x 48-bit RAM. The final spectrum of each set is emitted as
// (sum >> L) on an AXI4-Stream master. A frame-alignment checker resyncs the
// bin/frame counters on a misplaced or missing input tlast.
//
// Handshake rule (both streams): a beat transfers on a rising edge where
// tvalid && tready are both high. The master holds tdata/tlast stable while
// tvalid && !tready, and tvalid only drops after a transfer.
//
// Ports
//   aclk                 clock, rising edge
//   areset               asynchronous active-high reset
//   enable               0 forces IDLE, 1 allows SYNC then RUN
//   log_count_averages   L, number of averaged spectra is 2^L (values > 16 act as 16)
//   S_AXIS_fft_*         input bins, tdata[15:0] = re, tdata[31:16] = im (signed)
//   M_AXIS_power_*       averaged unsigned power, tlast on the last bin
//   sync_lost            one-cycle pulse on a frame-alignment error
module fft_power_averager #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FFT_LENGTH_LOG   = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        enable,
    input  logic [4:0]                  log_count_averages,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_fft_tdata,
    input  logic                        S_AXIS_fft_tvalid,
    input  logic                        S_AXIS_fft_tlast,
    output logic                        S_AXIS_fft_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_power_tdata,
    output logic                        M_AXIS_power_tvalid,
    output logic                        M_AXIS_power_tlast,
    input  logic                        M_AXIS_power_tready,
    output logic                        sync_lost
);

    localparam int FFT_LENGTH = 1 << FFT_LENGTH_LOG;
    localparam logic [FFT_LENGTH_LOG-1:0] LAST_BIN = FFT_LENGTH_LOG'(FFT_LENGTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // ------------------------------------------------------------------
    // Control: state, bin/frame counters, latched averaging exponent
    // ------------------------------------------------------------------
    logic [1:0]                state;
    logic [FFT_LENGTH_LOG-1:0] bin;
    logic [15:0]               frame;
    logic [4:0]                l_reg;

    logic        ce;
    logic        handshake;
    logic        run_beat;
    logic [4:0]  l_gpio;
    logic        set_start;
    logic [4:0]  l_beat;
    logic [16:0] last_frame_idx;
    logic        final_frame;
    logic        at_last_bin;
    logic        early_tlast;
    logic        missing_tlast;

    // One stall signal for the whole pipeline, driven by the output register.
    assign ce = !M_AXIS_power_tvalid || M_AXIS_power_tready;

    // Outside RUN every beat is dropped, so the input never stalls there.
    assign S_AXIS_fft_tready = !areset && ((state != ST_RUN) || ce);

    assign handshake = S_AXIS_fft_tvalid && S_AXIS_fft_tready;
    assign run_beat  = handshake && (state == ST_RUN) && enable;

    assign l_gpio    = (log_count_averages > 5'd16) ? 5'd16 : log_count_averages;
    assign set_start = (bin == '0) && (frame == 16'd0);
    // The first beat of a set already uses the freshly sampled exponent.
    assign l_beat         = set_start ? l_gpio : l_reg;
    assign last_frame_idx = (17'd1 << l_beat) - 17'd1;
    assign final_frame    = ({1'b0, frame} == last_frame_idx);

    assign at_last_bin   = (bin == LAST_BIN);
    assign early_tlast   = S_AXIS_fft_tlast && !at_last_bin;
    assign missing_tlast = !S_AXIS_fft_tlast && at_last_bin;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            bin       <= '0;
            frame     <= 16'd0;
            l_reg     <= 5'd0;
            sync_lost <= 1'b0;
        end else begin
            sync_lost <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bin   <= '0;
                    frame <= 16'd0;
                    if (enable) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    bin   <= '0;
                    frame <= 16'd0;
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (handshake && S_AXIS_fft_tlast) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        bin   <= '0;
                        frame <= 16'd0;
                    end else if (run_beat) begin
                        if (set_start) l_reg <= l_gpio;
                        sync_lost <= early_tlast || missing_tlast;
                        if (early_tlast) begin
                            // Treat the early tlast as a frame end and open a new set.
                            bin   <= '0;
                            frame <= 16'd0;
                        end else if (missing_tlast) begin
                            state <= ST_SYNC;
                            bin   <= '0;
                            frame <= 16'd0;
                        end else if (at_last_bin) begin
                            bin   <= '0;
                            frame <= final_frame ? 16'd0 : frame + 16'd1;
                        end else begin
                            bin <= bin + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    bin   <= '0;
                    frame <= 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: input capture -> S1 (power, RAM read) -> S2 (add, write
    // back, scale) -> S3 (output register)
    // ------------------------------------------------------------------
    logic                       in_valid;
    logic signed [15:0]         in_re;
    logic signed [15:0]         in_im;
    logic [FFT_LENGTH_LOG-1:0]  in_bin;
    logic                       in_first;
    logic                       in_final;
    logic [4:0]                 in_l;
    logic                       in_tlast;

    logic                       s1_valid;
    logic [31:0]                s1_pow;
    logic [FFT_LENGTH_LOG-1:0]  s1_bin;
    logic                       s1_first;
    logic                       s1_final;
    logic [4:0]                 s1_l;
    logic                       s1_tlast;

    logic                       s2_valid;
    logic [31:0]                s2_data;
    logic                       s2_tlast;

    logic                       m_valid;
    logic [31:0]                m_data;
    logic                       m_tlast;

    logic [47:0] acc_ram [0:FFT_LENGTH-1];
    logic [47:0] rd_data;

    logic signed [31:0] re_ext;
    logic signed [31:0] im_ext;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    logic [31:0]        pow;
    logic [47:0]        acc_sum;

    always_comb begin
        re_ext = 32'(in_re);
        im_ext = 32'(in_im);
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
        // Each square is at most 2^30, so the unsigned sum never wraps.
        pow    = $unsigned(re_sq) + $unsigned(im_sq);
    end

    // Frame 0 of a set ignores the stale RAM word: that is the only clear.
    always_comb begin
        acc_sum = (s1_first ? 48'd0 : rd_data) + {16'd0, s1_pow};
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_valid <= 1'b0;
            in_re    <= 16'sd0;
            in_im    <= 16'sd0;
            in_bin   <= '0;
            in_first <= 1'b0;
            in_final <= 1'b0;
            in_l     <= 5'd0;
            in_tlast <= 1'b0;
            s1_valid <= 1'b0;
            s1_pow   <= 32'd0;
            s1_bin   <= '0;
            s1_first <= 1'b0;
            s1_final <= 1'b0;
            s1_l     <= 5'd0;
            s1_tlast <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= 32'd0;
            s2_tlast <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= 32'd0;
            m_tlast  <= 1'b0;
        end else if (ce) begin
            in_valid <= run_beat;
            in_re    <= S_AXIS_fft_tdata[15:0];
            in_im    <= S_AXIS_fft_tdata[31:16];
            in_bin   <= bin;
            in_first <= (frame == 16'd0);
            in_final <= final_frame;
            in_l     <= l_beat;
            // A missing tlast on the last bin still closes the output frame.
            in_tlast <= S_AXIS_fft_tlast || at_last_bin;

            s1_valid <= in_valid && enable;
            s1_pow   <= pow;
            s1_bin   <= in_bin;
            s1_first <= in_first;
            s1_final <= in_final;
            s1_l     <= in_l;
            s1_tlast <= in_tlast;

            s2_valid <= s1_valid && s1_final && enable;
            s2_data  <= 32'(acc_sum >> s1_l);
            s2_tlast <= s1_tlast;

            m_valid  <= s2_valid && enable;
            if (s2_valid) begin
                m_data  <= s2_data;
                m_tlast <= s2_tlast;
            end
        end else if (!enable) begin
            // Stalled while being disabled: drop internal beats, keep the
            // output register untouched until it is accepted.
            in_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end
    end

    // Accumulator RAM: read when a beat enters S1, written when it leaves S1.
    // A bin is read again at least FFT_LENGTH beats later, so no forwarding.
    always_ff @(posedge aclk) begin
        if (ce) begin
            rd_data <= acc_ram[in_bin];
            if (s1_valid && enable && !s1_final) begin
                acc_ram[s1_bin] <= acc_sum;
            end
        end
    end

    assign M_AXIS_power_tdata  = m_data;
    assign M_AXIS_power_tvalid = m_valid;
    assign M_AXIS_power_tlast  = m_tlast;

endmodule

// File: tb/tb_fft_power_averager.sv
module tb_fft_power_averager;

    localparam int N = 8;

    logic        aclk;
    logic        areset;
    logic        enable;
    logic [4:0]  lca;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        sync_lost;

    fft_power_averager #(
        .AXIS_TDATA_WIDTH(32),
        .FFT_LENGTH_LOG(3)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .enable(enable),
        .log_count_averages(lca),
        .S_AXIS_fft_tdata(s_tdata),
        .S_AXIS_fft_tvalid(s_tvalid),
        .S_AXIS_fft_tlast(s_tlast),
        .S_AXIS_fft_tready(s_tready),
        .M_AXIS_power_tdata(m_tdata),
        .M_AXIS_power_tvalid(m_tvalid),
        .M_AXIS_power_tlast(m_tlast),
        .M_AXIS_power_tready(m_tready),
        .sync_lost(sync_lost)
    );

    // clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          re0;
        int          re_step;
        int          im0;
        int          l;
        logic [31:0] exp_pow;
    } vec_t;

    vec_t        vecs [6];
    logic [32:0] exp_q [$];
    int          n_checks;
    int          n_pass;
    int          sl_count;
    logic        lat_armed;
    logic [63:0] lat_t;
    logic        stall_prev;
    logic [32:0] held;
    logic [31:0] bp_exp [8];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic push_frame(input logic [31:0] val, input int nbeats);
        for (int b = 0; b < nbeats; b++) exp_q.push_back({(b == nbeats - 1), val});
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat's handshake.
    task automatic send_beat(input int re, input int im, input logic last, input logic arm);
        int w;
        w = 0;
        s_tdata  = {16'(im), 16'(re)};
        s_tvalid = 1'b1;
        s_tlast  = last;
        @(negedge aclk);
        while (!s_tready && w < 200) begin
            @(negedge aclk);
            w++;
        end
        if (!s_tready) begin
            n_checks++;
            $display("FAIL s_tready_timeout: got 0 expected 1 within 200 cycles");
        end
        @(posedge aclk);
        if (arm) begin
            lat_t     = $time;
            lat_armed = 1'b1;
        end
        #1;
    endtask

    task automatic send_frame(input int re0, input int dre, input int im0, input int dim,
                              input int nbeats, input logic with_tlast, input logic arm);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(re0 + dre * b, im0 + dim * b, with_tlast && (b == nbeats - 1),
                      arm && (b == 0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(posedge aclk);
            #1;
            w++;
        end
        check("drain_outputs", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        idle(4);
    endtask

    // Re-enter SYNC and consume one discarded alignment frame.
    task automatic resync(input int l);
        lca    = 5'(l);
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        send_frame(7, 0, 0, 0, N, 1'b1, 1'b0);
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (stall_prev) begin
                    check("hold_tvalid", 64'(m_tvalid), 64'(1));
                    check("hold_data", 64'({m_tlast, m_tdata}), 64'(held));
                end
                if (lat_armed && m_tvalid) begin
                    check("latency", $time - 64'd5 - lat_t, 64'd30);
                    lat_armed = 1'b0;
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %0d tlast %0d expected no beat",
                                 m_tdata, m_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", 64'({m_tlast, m_tdata}), 64'(e));
                    end
                end
                if (sync_lost) sl_count++;
                stall_prev = m_tvalid && !m_tready;
                held       = {m_tlast, m_tdata};
            end
        end
    endtask

    initial begin
        int sl_base;
        int w;
        n_checks   = 0;
        n_pass     = 0;
        sl_count   = 0;
        lat_armed  = 1'b0;
        lat_t      = 64'd0;
        stall_prev = 1'b0;
        held       = 33'd0;

        vecs[0] = '{re0: 3,      re_step: 0, im0: 4,      l: 0, exp_pow: 32'd25};
        vecs[1] = '{re0: 1,      re_step: 1, im0: 0,      l: 2, exp_pow: 32'd7};
        vecs[2] = '{re0: -32768, re_step: 0, im0: -32768, l: 4, exp_pow: 32'd2147483648};
        vecs[3] = '{re0: -5,     re_step: 0, im0: 7,      l: 1, exp_pow: 32'd74};
        vecs[4] = '{re0: 100,    re_step: 3, im0: -200,   l: 3, exp_pow: 32'd52257};
        vecs[5] = '{re0: 1,      re_step: 1, im0: 0,      l: 1, exp_pow: 32'd2};
        bp_exp  = '{32'd1, 32'd5, 32'd13, 32'd25, 32'd41, 32'd61, 32'd85, 32'd113};

        // reset
        areset   = 1'b1;
        enable   = 1'b0;
        lca      = 5'd0;
        s_tdata  = 32'h0001_0001;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        fork
            monitor();
        join_none

        repeat (5) begin
            @(negedge aclk);
            check("rst_s_tready", 64'(s_tready), 64'(0));
            check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
            check("rst_m_data", 64'({m_tlast, m_tdata}), 64'(0));
            check("rst_sync_lost", 64'(sync_lost), 64'(0));
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("idle_s_tready", 64'(s_tready), 64'(1));
            check("idle_m_tvalid", 64'(m_tvalid), 64'(0));
        end
        @(posedge aclk);
        #1;
        idle(2);

        // table: each record runs two full averaging sets after a sync frame
        for (int i = 0; i < 6; i++) begin
            resync(vecs[i].l);
            for (int set = 0; set < 2; set++) begin
                for (int f = 0; f < (1 << vecs[i].l); f++) begin
                    if (f == (1 << vecs[i].l) - 1) push_frame(vecs[i].exp_pow, N);
                    send_frame(vecs[i].re0 + vecs[i].re_step * f, 0, vecs[i].im0, 0, N, 1'b1,
                               (set == 0) && (f == (1 << vecs[i].l) - 1));
                end
            end
            drain();
        end

        // backpressure: 5 stalled cycles mid-output, L=0, per-bin varying data
        resync(0);
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < N; b++) exp_q.push_back({(b == N - 1), bp_exp[b]});
        fork
            begin
                for (int k = 0; k < 3; k++) send_frame(1, 1, 0, 1, N, 1'b1, 1'b0);
            end
            begin
                w = 0;
                while (!m_tvalid && w < 100) begin
                    @(negedge aclk);
                    w++;
                end
                check("bp_output_seen", 64'(m_tvalid), 64'(1));
                repeat (3) @(posedge aclk);
                #1;
                m_tready = 1'b0;
                repeat (5) begin
                    @(negedge aclk);
                    check("bp_s_tready", 64'(s_tready), 64'(0));
                end
                @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();

        // early tlast at bin 5 in the final frame of an L=1 set
        resync(1);
        sl_base = sl_count;
        send_frame(2, 0, 0, 0, N, 1'b1, 1'b0);
        push_frame(32'd10, 6);
        send_frame(4, 0, 0, 0, 6, 1'b1, 1'b0);
        push_frame(32'd5, N);
        send_frame(1, 0, 0, 0, N, 1'b1, 1'b0);
        send_frame(3, 0, 0, 0, N, 1'b1, 1'b0);
        drain();
        check("early_tlast_sync_lost", 64'(sl_count - sl_base), 64'(1));

        // missing tlast, L=0: forced tlast on output, then back through SYNC
        resync(0);
        sl_base = sl_count;
        push_frame(32'd25, N);
        send_frame(3, 0, 4, 0, N, 1'b0, 1'b0);
        send_frame(9, 0, 0, 0, N, 1'b1, 1'b0);
        push_frame(32'd1, N);
        send_frame(1, 0, 0, 0, N, 1'b1, 1'b0);
        drain();
        check("missing_tlast_sync_lost", 64'(sl_count - sl_base), 64'(1));

        // drop enable mid-set, L=2
        resync(2);
        sl_base = sl_count;
        send_frame(5, 0, 0, 0, N, 1'b1, 1'b0);
        send_frame(5, 0, 0, 0, 3, 1'b0, 1'b0);
        enable = 1'b0;
        idle(2);
        send_frame(9, 0, 0, 0, N, 1'b1, 1'b0);
        @(negedge aclk);
        check("disabled_s_tready", 64'(s_tready), 64'(1));
        @(posedge aclk);
        #1;
        idle(6);
        check("disabled_no_output", 64'(exp_q.size()), 64'(0));
        enable = 1'b1;
        send_frame(7, 0, 0, 0, N, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            if (f == 3) push_frame(32'd7, N);
            send_frame(f + 1, 0, 0, 0, N, 1'b1, 1'b0);
        end
        drain();
        check("disable_sync_lost", 64'(sl_count - sl_base), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_power_averager.md
# fft_power_averager

Downstream neighbour of the Fourier transform stage. Consumes complex FFT bins (16-bit re/im packed in 32 bits), computes the power |X|² per bin and averages it over 2^log_count_averages consecutive spectra. It emits one averaged 32-bit power spectrum per averaging set on an AXI4-Stream master toward the DMA/readout path.

## Interface
- AXIS_TDATA_WIDTH, 32: input/output stream width. Input packing: [15:0] re, [31:16] im, both signed.
- FFT_LENGTH_LOG, 8: log2 of bins per spectrum. Legal range 3..12.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  GPIO[0]; 0 forces IDLE.
- log_count_averages  in  5  GPIO[5:1]; legal 0..16; values >16 are treated as 16.
- S_AXIS_fft_tdata  in  32  FFT bin.
- S_AXIS_fft_tvalid  in  1.
- S_AXIS_fft_tlast  in  1  marks bin FFT_LENGTH-1.
- S_AXIS_fft_tready  out  1.
- M_AXIS_power_tdata  out  32  unsigned averaged power.
- M_AXIS_power_tvalid  out  1.
- M_AXIS_power_tlast  out  1  marks last bin of an averaged spectrum.
- M_AXIS_power_tready  in  1.
- sync_lost  out  1  one-cycle pulse on frame-alignment error.

## Operation
- Power: p = re*re + im*im, 32-bit unsigned; max 2^31 at re=im=-32768, no overflow.
- Accumulator RAM: FFT_LENGTH words × 48 bits, read-modify-write per bin.
- Lazy clear: frame 0 of a set writes p; later frames write acc+p. No explicit clear pass.
- Final frame of a set (f = 2^L-1): the block does not write back. It emits (acc+p) >> L, 32 bits, which always fits. M tlast = input tlast.
- L is latched at bin 0 of frame 0 of every set. Mid-set GPIO changes take effect at the next set.
- States:
  - IDLE: enable=0. S tready=1, beats discarded. Goes to SYNC when enable=1.
  - SYNC: discards beats through the first tlast, then goes to RUN with f=0, bin=0.
  - RUN: bin counter 0..FFT_LENGTH-1 and frame counter f.
  - In RUN, enable=0 goes to IDLE immediately. No output beat is forced; a partial output frame is left unterminated, and the downstream DMA resyncs on tlast.
- Alignment error in RUN: tlast at bin≠FFT_LENGTH-1, or no tlast at bin FFT_LENGTH-1.
  - sync_lost pulses.
  - If in the final frame, the erroneous beat is still emitted with M tlast forced to 1.
  - Early tlast: next beat is bin 0 with f=0 (new set).
  - Missing tlast: go to SYNC.

## Timing
- 3-stage pipeline:
  - S1 registers the products and issues the RAM read.
  - S2 adds and writes back.
  - S3 is the output register.
- Latency: a beat accepted at edge N appears on M_AXIS at edge N+3 (final frame only).
- Global stall: ce = !M_AXIS_power_tvalid || M_AXIS_power_tready. S_AXIS_fft_tready = ce (1 in IDLE/SYNC).
- A bubble (tvalid=0) advances the pipeline with no write and no output.
- AXIS rules: M tdata/tlast are held stable while tvalid && !tready. tvalid never drops without a handshake.
- RAM hazard: the same bin is re-read ≥FFT_LENGTH ≥8 accepted beats after its write, so no forwarding is needed.
- Reset values: S tready=0 while areset is high, then 1. M tvalid=0, tdata=0, tlast=0, sync_lost=0. State IDLE, counters 0, latched L=0. RAM contents don't care because of the lazy clear.
- areset mid-set: all pipeline beats are dropped. The block restarts in IDLE, then SYNC.

## Test plan
- Reset: hold areset 5 cycles with tvalid=1.
  - S tready=0 and M tvalid=0 during reset.
  - After release with enable=0: tready=1, no output.
- FFT_LENGTH_LOG=3, L=0, re=3, im=4 on every bin. After one sync frame:
  - every frame outputs 8 beats of 25, tlast on the 8th;
  - first output 3 cycles after its input handshake.
- L=2, all bins of frame f carry re=f+1, im=0, for f=0..3. Sums are 1+4+9+16=30:
  - output is 8 beats of 7 after frame 3 only;
  - no output during frames 0–2;
  - the next set starts clean (lazy clear verified).
- L=4, re=im=-32768 for all bins:
  - output 2147483648 per bin;
  - no overflow in the 48-bit accumulator.
- Backpressure: M tready=0 for 5 cycles mid-output frame.
  - S tready=0 for those cycles;
  - M tdata held stable;
  - the output sequence is identical to the tready=1 run.
- Early tlast at bin 5 (L=1):
  - sync_lost pulses once;
  - the next beat starts a new set;
  - the following spectra average correctly.
- Drop enable mid-set: immediate IDLE, beats discarded. Re-enable: SYNC, then valid output after a full set.
